// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : LoongArch CSR file with exception/ertn commit, constant timer,
//            64-bit stable counter and interrupt pending detection.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic [1:0]  crmd_plv,
    output logic [63:0] stable_cnt
);

    localparam logic [13:0] c_CRMD   = 14'h000;
    localparam logic [13:0] c_PRMD   = 14'h001;
    localparam logic [13:0] c_ECFG   = 14'h004;
    localparam logic [13:0] c_ESTAT  = 14'h005;
    localparam logic [13:0] c_ERA    = 14'h006;
    localparam logic [13:0] c_BADV   = 14'h007;
    localparam logic [13:0] c_EENTRY = 14'h00C;
    localparam logic [13:0] c_SAVE0  = 14'h030;
    localparam logic [13:0] c_SAVE1  = 14'h031;
    localparam logic [13:0] c_SAVE2  = 14'h032;
    localparam logic [13:0] c_SAVE3  = 14'h033;
    localparam logic [13:0] c_TID    = 14'h040;
    localparam logic [13:0] c_TCFG   = 14'h041;
    localparam logic [13:0] c_TVAL   = 14'h042;
    localparam logic [13:0] c_TICLR  = 14'h044;
    localparam logic [5:0]  c_ECODE_ADEF = 6'h08;
    localparam logic [5:0]  c_ECODE_ALE  = 6'h09;

    logic [8:0]  r_crmd;
    logic [2:0]  r_prmd;
    logic [12:0] r_ecfg_lie;
    logic [1:0]  r_is_sw;
    logic [7:0]  r_is_hw;
    logic        r_is_timer;
    logic        r_is_ipi;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [25:0] r_eentry;
    logic [31:0] r_save [4];
    logic [31:0] r_tid;
    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic [63:0] r_stable;

    logic        w_unused;
    logic [12:0] w_is;
    logic [31:0] w_merged;
    logic        w_wr;
    logic        w_timer_set;
    logic        w_ticlr;
    logic        w_tcfg_load;

    assign w_unused = csr_re;
    assign w_is     = {r_is_ipi, r_is_timer, 1'b0, r_is_hw, r_is_sw};

    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            c_CRMD:   csr_rvalue = {23'b0, r_crmd};
            c_PRMD:   csr_rvalue = {29'b0, r_prmd};
            c_ECFG:   csr_rvalue = {19'b0, r_ecfg_lie};
            c_ESTAT:  csr_rvalue = {1'b0, r_esubcode, r_ecode, 3'b0, w_is};
            c_ERA:    csr_rvalue = r_era;
            c_BADV:   csr_rvalue = r_badv;
            c_EENTRY: csr_rvalue = {r_eentry, 6'b0};
            c_SAVE0, c_SAVE1, c_SAVE2, c_SAVE3:
                      csr_rvalue = r_save[csr_num[1:0]];
            c_TID:    csr_rvalue = r_tid;
            c_TCFG:   csr_rvalue = r_tcfg;
            c_TVAL:   csr_rvalue = r_tval;
            default:  csr_rvalue = '0;
        endcase
    end

    // Read value already zeroes reserved bits, so it serves as the merge base.
    assign w_merged    = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign w_wr        = csr_we & ~wb_ex;
    assign w_timer_set = r_tcfg[0] & (r_tval == 32'h0);
    assign w_ticlr     = w_wr & (csr_num == c_TICLR) & csr_wmask[0] & csr_wvalue[0];
    assign w_tcfg_load = w_wr & (csr_num == c_TCFG) & w_merged[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_crmd <= 9'h008;
            r_prmd <= 3'b0;
        end else if (wb_ex) begin
            r_crmd[2:0] <= 3'b0;
            r_prmd      <= r_crmd[2:0];
        end else if (ertn_flush) begin
            r_crmd[2:0] <= r_prmd;
        end else begin
            if (w_wr && csr_num == c_CRMD) r_crmd <= w_merged[8:0];
            if (w_wr && csr_num == c_PRMD) r_prmd <= w_merged[2:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ecfg_lie <= '0;
            r_is_sw    <= '0;
            r_is_hw    <= '0;
            r_is_timer <= 1'b0;
            r_is_ipi   <= 1'b0;
            r_ecode    <= '0;
            r_esubcode <= '0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (w_timer_set)  r_is_timer <= 1'b1;
            else if (w_ticlr) r_is_timer <= 1'b0;
            if (wb_ex) begin
                r_ecode    <= wb_ecode;
                r_esubcode <= wb_esubcode;
            end
            if (w_wr && csr_num == c_ECFG)  r_ecfg_lie <= w_merged[12:0] & 13'h1BFF;
            if (w_wr && csr_num == c_ESTAT) r_is_sw    <= w_merged[1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_era    <= '0;
            r_badv   <= '0;
            r_eentry <= '0;
            r_tid    <= TID_RESET;
            r_tcfg   <= '0;
            for (int i = 0; i < 4; i++) r_save[i] <= '0;
        end else if (wb_ex) begin
            r_era <= wb_ex_pc;
            if (wb_ecode == c_ECODE_ADEF)     r_badv <= wb_ex_pc;
            else if (wb_ecode == c_ECODE_ALE) r_badv <= wb_vaddr;
        end else if (w_wr) begin
            case (csr_num)
                c_ERA:    r_era    <= w_merged;
                c_BADV:   r_badv   <= w_merged;
                c_EENTRY: r_eentry <= w_merged[31:6];
                c_SAVE0, c_SAVE1, c_SAVE2, c_SAVE3:
                          r_save[csr_num[1:0]] <= w_merged;
                c_TID:    r_tid    <= w_merged;
                c_TCFG:   r_tcfg   <= w_merged;
                default:  ;
            endcase
        end
    end

    // All-ones is the idle value: a one-shot timer decrements 0 into it and parks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tval <= 32'hFFFF_FFFF;
        end else if (w_tcfg_load) begin
            r_tval <= {w_merged[31:2], 2'b00};
        end else if (r_tcfg[0] && r_tval != 32'hFFFF_FFFF) begin
            if (r_tval == 32'h0 && r_tcfg[1]) r_tval <= {r_tcfg[31:2], 2'b00};
            else                              r_tval <= r_tval - 32'h1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_stable <= '0;
        else         r_stable <= r_stable + 64'h1;
    end

    assign has_int    = (|(w_is & r_ecfg_lie)) & r_crmd[2];
    assign ex_entry   = {r_eentry, 6'b0};
    assign ertn_entry = r_era;
    assign crmd_plv   = r_crmd[1:0];
    assign stable_cnt = r_stable;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Directed self-checking bench for csr_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] TID_VAL = 32'hA5A5_0001;

    logic        clk;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_ex_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic [1:0]  crmd_plv;
    logic [63:0] stable_cnt;

    int checks = 0;
    int errors = 0;

    csr_file #(.TID_RESET(TID_VAL)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .crmd_plv(crmd_plv), .stable_cnt(stable_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] n);
        csr_num = n;
        @(negedge clk);
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
        csr_we = 1'b1; csr_num = n; csr_wvalue = v; csr_wmask = m;
        tick;
        csr_we = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0;
        csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0;
        wb_esubcode = '0; wb_ex_pc = '0; wb_vaddr = '0; ertn_flush = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        repeat (3) tick;
        resetn = 1'b1;
        rd(14'h000);
        checks++; if (csr_rvalue !== 32'h8) begin errors++; $display("FAIL reset_crmd got %h exp %h", csr_rvalue, 32'h8); end
        checks++; if (stable_cnt !== 64'd0) begin errors++; $display("FAIL stable_0 got %0d exp 0", stable_cnt); end
        rd(14'h040);
        checks++; if (csr_rvalue !== TID_VAL) begin errors++; $display("FAIL reset_tid got %h exp %h", csr_rvalue, TID_VAL); end
        checks++; if (stable_cnt !== 64'd1) begin errors++; $display("FAIL stable_1 got %0d exp 1", stable_cnt); end
        rd(14'h042);
        checks++; if (csr_rvalue !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tval got %h exp ffffffff", csr_rvalue); end
        checks++; if (stable_cnt !== 64'd2) begin errors++; $display("FAIL stable_2 got %0d exp 2", stable_cnt); end
    endtask

    task automatic test_masked_write;
        wr(14'h030, 32'h1234_5678, 32'hFFFF_FFFF);
        csr_we = 1'b1; csr_num = 14'h030; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'h0000_FF00;
        @(negedge clk);
        checks++; if (csr_rvalue !== 32'h1234_5678) begin errors++; $display("FAIL save0_old got %h exp 12345678", csr_rvalue); end
        tick;
        csr_we = 1'b0;
        rd(14'h030);
        checks++; if (csr_rvalue !== 32'h1234_FF78) begin errors++; $display("FAIL save0_new got %h exp 1234ff78", csr_rvalue); end
        wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h004);
        checks++; if (csr_rvalue !== 32'h0000_1BFF) begin errors++; $display("FAIL ecfg_bits got %h exp 00001bff", csr_rvalue); end
        wr(14'h004, 32'h0, 32'hFFFF_FFFF);
        wr(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h00C);
        checks++; if (csr_rvalue !== 32'hFFFF_FFC0 || ex_entry !== 32'hFFFF_FFC0) begin errors++; $display("FAIL eentry got %h/%h exp ffffffc0", csr_rvalue, ex_entry); end
        wr(14'h050, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h050);
        checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL unimpl_read got %h exp 0", csr_rvalue); end
    endtask

    task automatic test_exception;
        wr(14'h000, 32'h7, 32'hFFFF_FFFF);
        csr_we = 1'b1; csr_num = 14'h006; csr_wvalue = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF;
        wb_ex = 1'b1; wb_ecode = 6'h9; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0100; wb_vaddr = 32'h3;
        tick;
        csr_we = 1'b0; wb_ex = 1'b0;
        rd(14'h000);
        checks++; if (csr_rvalue !== 32'h0 || crmd_plv !== 2'd0) begin errors++; $display("FAIL ex_crmd got %h plv %0d exp 0", csr_rvalue, crmd_plv); end
        rd(14'h001);
        checks++; if (csr_rvalue !== 32'h7) begin errors++; $display("FAIL ex_prmd got %h exp 7", csr_rvalue); end
        rd(14'h006);
        checks++; if (csr_rvalue !== 32'h1C00_0100) begin errors++; $display("FAIL ex_era got %h exp 1c000100", csr_rvalue); end
        rd(14'h007);
        checks++; if (csr_rvalue !== 32'h3) begin errors++; $display("FAIL ex_badv_ale got %h exp 3", csr_rvalue); end
        rd(14'h005);
        checks++; if (csr_rvalue !== 32'h0009_0000) begin errors++; $display("FAIL ex_estat got %h exp 00090000", csr_rvalue); end
    endtask

    task automatic test_ertn;
        ertn_flush = 1'b1;
        tick;
        ertn_flush = 1'b0;
        rd(14'h000);
        checks++; if (csr_rvalue !== 32'h7 || crmd_plv !== 2'd3) begin errors++; $display("FAIL ertn_crmd got %h plv %0d exp 7/3", csr_rvalue, crmd_plv); end
        checks++; if (ertn_entry !== 32'h1C00_0100) begin errors++; $display("FAIL ertn_entry got %h exp 1c000100", ertn_entry); end
    endtask

    task automatic test_interrupt_lines;
        wr(14'h004, 32'h4, 32'hFFFF_FFFF);
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL int_idle got %b exp 0", has_int); end
        hw_int_in = 8'h01;
        tick;
        rd(14'h005);
        checks++; if (csr_rvalue !== 32'h0009_0004 || has_int !== 1'b1) begin errors++; $display("FAIL hw_int got %h/%b exp 00090004/1", csr_rvalue, has_int); end
        hw_int_in = 8'h00; ipi_int_in = 1'b1;
        tick;
        rd(14'h005);
        checks++; if (csr_rvalue !== 32'h0009_1000 || has_int !== 1'b0) begin errors++; $display("FAIL ipi got %h/%b exp 00091000/0", csr_rvalue, has_int); end
        ipi_int_in = 1'b0;
        wr(14'h004, 32'h800, 32'hFFFF_FFFF);
    endtask

    task automatic test_timer_periodic;
        bit found;
        wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
        csr_num = 14'h042;
        for (int k = 8; k >= 0; k--) begin
            @(negedge clk);
            checks++; if (csr_rvalue !== 32'(k)) begin errors++; $display("FAIL tval_count got %h exp %h", csr_rvalue, 32'(k)); end
        end
        @(negedge clk);
        checks++; if (csr_rvalue !== 32'h8) begin errors++; $display("FAIL tval_reload got %h exp 8", csr_rvalue); end
        csr_num = 14'h005; #1;
        checks++; if (csr_rvalue[11] !== 1'b1 || has_int !== 1'b1) begin errors++; $display("FAIL timer_set got %b/%b exp 1/1", csr_rvalue[11], has_int); end
        wr(14'h044, 32'h1, 32'h1);
        rd(14'h005);
        checks++; if (csr_rvalue[11] !== 1'b0 || has_int !== 1'b0) begin errors++; $display("FAIL ticlr got %b/%b exp 0/0", csr_rvalue[11], has_int); end
        csr_num = 14'h044; #1;
        checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL ticlr_read got %h exp 0", csr_rvalue); end
        csr_num = 14'h042;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (csr_rvalue == 32'h0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL tval_zero_wait got timeout exp 0"); end
        wr(14'h044, 32'h1, 32'h1);
        rd(14'h005);
        checks++; if (csr_rvalue[11] !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", csr_rvalue[11]); end
        wr(14'h041, 32'h0, 32'hFFFF_FFFF);
        wr(14'h044, 32'h1, 32'h1);
        rd(14'h005);
        checks++; if (csr_rvalue[11] !== 1'b0) begin errors++; $display("FAIL timer_off_clr got %b exp 0", csr_rvalue[11]); end
    endtask

    task automatic test_timer_oneshot;
        logic [31:0] exp_seq [8];
        exp_seq = '{32'h4, 32'h3, 32'h2, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        wr(14'h041, 32'h5, 32'hFFFF_FFFF);
        csr_num = 14'h042;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (csr_rvalue !== exp_seq[k]) begin errors++; $display("FAIL oneshot_tval[%0d] got %h exp %h", k, csr_rvalue, exp_seq[k]); end
        end
        csr_num = 14'h005; #1;
        checks++; if (csr_rvalue[11] !== 1'b1) begin errors++; $display("FAIL oneshot_set got %b exp 1", csr_rvalue[11]); end
        wr(14'h044, 32'h1, 32'h1);
        repeat (4) @(negedge clk);
        checks++; if (csr_rvalue[11] !== 1'b0) begin errors++; $display("FAIL oneshot_once got %b exp 0", csr_rvalue[11]); end
    endtask

    task automatic test_badv_variants;
        wb_ex = 1'b1; wb_ecode = 6'h8; wb_esubcode = 9'h1; wb_ex_pc = 32'h1C00_0200; wb_vaddr = 32'h5;
        tick;
        wb_ex = 1'b0;
        rd(14'h007);
        checks++; if (csr_rvalue !== 32'h1C00_0200) begin errors++; $display("FAIL badv_adef got %h exp 1c000200", csr_rvalue); end
        rd(14'h005);
        checks++; if (csr_rvalue !== 32'h0048_0000) begin errors++; $display("FAIL estat_adef got %h exp 00480000", csr_rvalue); end
        wb_ex = 1'b1; wb_ecode = 6'h1; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0300; wb_vaddr = 32'h7;
        tick;
        wb_ex = 1'b0;
        rd(14'h007);
        checks++; if (csr_rvalue !== 32'h1C00_0200) begin errors++; $display("FAIL badv_other got %h exp 1c000200", csr_rvalue); end
        checks++; if (ertn_entry !== 32'h1C00_0300) begin errors++; $display("FAIL era_other got %h exp 1c000300", ertn_entry); end
    endtask

    task automatic test_reset_midop;
        wr(14'h041, 32'h401, 32'hFFFF_FFFF);
        repeat (3) tick;
        csr_num = 14'h042;
        resetn = 1'b0;
        #1;
        checks++; if (csr_rvalue !== 32'hFFFF_FFFF || stable_cnt !== 64'd0) begin errors++; $display("FAIL midrst_async got %h/%0d exp ffffffff/0", csr_rvalue, stable_cnt); end
        csr_num = 14'h001; #1;
        checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL midrst_prmd got %h exp 0", csr_rvalue); end
        csr_num = 14'h000; #1;
        checks++; if (csr_rvalue !== 32'h8) begin errors++; $display("FAIL midrst_crmd got %h exp 8", csr_rvalue); end
        tick;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset;
        test_masked_write;
        test_exception;
        test_ertn;
        test_interrupt_lines;
        test_timer_periodic;
        test_timer_oneshot;
        test_badv_variants;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_file.md
Name: csr_file

Overview:
- Control/status register file for the LoongArch pipeline. It is the responder for the CSR access and exception-commit interface driven by the write-back stage.
- It serves combinational CSR reads and mask-qualified CSR writes.
- It records exception and ertn side effects, and runs the constant timer and the 64-bit stable counter.
- It reports a pending interrupt to the front end, and supplies the exception entry and ertn return addresses.

Parameters:
- TID_RESET, 32'h0, reset value of the TID CSR.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- csr_re  in  1  read strobe (informational; the read path is always live).
- csr_num  in  14  CSR address for read and write.
- csr_rvalue  out  32  combinational read data for csr_num.
- csr_we  in  1  write enable, already qualified by stage valid.
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- wb_ex  in  1  exception commit.
- wb_ecode  in  6  exception code.
- wb_esubcode  in  9  exception subcode.
- wb_ex_pc  in  32  pc of the faulting instruction.
- wb_vaddr  in  32  faulting data address.
- ertn_flush  in  1  ertn commit.
- hw_int_in  in  8  hardware interrupt lines (level).
- ipi_int_in  in  1  inter-processor interrupt (level).
- has_int  out  1  interrupt pending and enabled.
- ex_entry  out  32  EENTRY value.
- ertn_entry  out  32  ERA value.
- crmd_plv  out  2  current privilege level.
- stable_cnt  out  64  stable counter.

Behaviour:
- Implemented CSRs:
  - CRMD 0x0
  - PRMD 0x1
  - ECFG 0x4
  - ESTAT 0x5
  - ERA 0x6
  - BADV 0x7
  - EENTRY 0xC
  - SAVE0-3 0x30-0x33
  - TID 0x40
  - TCFG 0x41
  - TVAL 0x42
  - TICLR 0x44
- Any other csr_num reads 0; writes to it are ignored.
- Write rule: on a clock where csr_we=1 and wb_ex=0, each writable bit takes (old & ~wmask) | (wvalue & wmask). Read-only and reserved bits are unchanged and read as 0.
- CRMD:
  - Fields: PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7]; bits [8:0] are writable.
  - Reset value is 32'h8.
  - wb_ex: PLV<=0, IE<=0.
  - ertn_flush without wb_ex: PLV<=PRMD.PPLV, IE<=PRMD.PIE.
- PRMD:
  - Fields: PPLV[1:0], PIE[2]; reset 0.
  - wb_ex: PPLV<=CRMD.PLV, PIE<=CRMD.IE, using the pre-update values.
- ECFG:
  - LIE is bits [9:0] and [12:11]; bit 10 reads 0.
  - Reset 0.
- ESTAT:
  - IS[1:0] is software-writable.
  - IS[9:2]<=hw_int_in every cycle.
  - IS[11] is the timer flag.
  - IS[12]<=ipi_int_in every cycle.
  - Ecode[21:16] and EsubCode[30:22] are loaded only on wb_ex.
  - Reset 0.
- ERA: wb_ex -> ERA<=wb_ex_pc; writable otherwise; reset 0.
- BADV:
  - On wb_ex with ecode 0x8 (ADEF): BADV<=wb_ex_pc.
  - On wb_ex with ecode 0x9 (ALE): BADV<=wb_vaddr.
  - Other ecodes leave BADV unchanged.
  - Writable; reset 0.
- EENTRY: bits [31:6] writable, [5:0] read 0; reset 0.
- SAVE0-3: fully writable; reset 0.
- TID: fully writable; reset TID_RESET.
- TCFG: En[0], Periodic[1], InitVal[31:2]; reset 0.
- Timer counter (TVAL read value):
  - Reset 32'hFFFF_FFFF.
  - A TCFG write with new En=1 loads {new InitVal,2'b00}.
  - Else, if En and counter != FFFF_FFFF:
    - counter==0 and Periodic -> reload {InitVal,2'b00};
    - otherwise decrement.
  - One-shot mode therefore stops at FFFF_FFFF.
- Timer interrupt, ESTAT.IS[11]:
  - Set when En=1 and counter==0.
  - Cleared by a TICLR write with wmask[0] & wvalue[0].
  - If set and clear happen in the same cycle, set wins.
  - TICLR reads 0.
- stable_cnt: 64-bit up-counter, reset 0, increments every cycle, wraps at 2^64-1 to 0.
- Priority: wb_ex > ertn_flush > csr_we for every CSR these events touch. If wb_ex=1, all software writes that cycle are dropped.
- Combinational outputs:
  - has_int = |(ESTAT.IS[12:0] & ECFG.LIE) & CRMD.IE.
  - ex_entry = EENTRY.
  - ertn_entry = ERA.
  - crmd_plv = CRMD.PLV.
- Read timing: a read in the same cycle as a write returns the old value; the new value is visible the next cycle.
- Reset mid-operation: asynchronous return to all reset values, including the timer counter and stable_cnt.

Test Plan:
- Reset: deassert resetn, then read 0x0, 0x40, 0x42 -> 32'h8, TID_RESET, 32'hFFFF_FFFF; stable_cnt counts 0,1,2...
- Masked write: write 0x30 with wvalue=32'hFFFF_FFFF, wmask=32'h0000_FF00 over 32'h1234_5678 -> read 32'h1234_FF78 the next cycle, old value during the write cycle.
- Exception:
  - Setup: CRMD=32'h7 (PLV3, IE=1).
  - Stimulus: wb_ex, ecode 0x9, esubcode 0, pc 32'h1C00_0100, vaddr 32'h0000_0003, with a simultaneous csr_we to ERA.
  - Response: CRMD.PLV=0, IE=0; PRMD=32'h7; ERA=32'h1C00_0100; BADV=32'h3; ESTAT[21:16]=6'h9; the write is dropped.
- ertn: following the exception, ertn_flush -> CRMD.PLV=3, IE=1; ertn_entry=32'h1C00_0100.
- Timer:
  - Write TCFG=32'h0000_000B (InitVal=2, En, Periodic) -> counter reads 8,7,...,0.
  - IS[11] sets at counter==0, then the counter reloads 8.
  - With ECFG=32'h800 and CRMD.IE=1, has_int=1.
  - A TICLR write of 1 clears IS[11]; if that write lands on a counter==0 cycle, IS[11] stays set.
- One-shot timer: TCFG=32'h5 -> counter 4..0 then FFFF_FFFF and holds; IS[11] sets once.
